// File: rtl/axi_mem_tester.sv
// AXI4 burst memory tester: fills the address region with a seeded address
// pattern using INCR write bursts, then reads it back and counts mismatches.
module axi_mem_tester #(
    parameter int unsigned G_DATAWIDTH = 32,
    parameter int unsigned G_ADDRWIDTH = 10,
    parameter int unsigned G_ID_WIDTH  = 4,
    parameter int unsigned G_BURST_LEN = 16
) (
    input  logic                       s_aclk,
    input  logic                       s_areset,
    input  logic                       start,
    input  logic [31:0]                seed,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [15:0]                err_count,
    output logic [G_ADDRWIDTH-1:0]     first_err_addr,
    output logic [G_ID_WIDTH-1:0]      m_axi_awid,
    output logic [G_ADDRWIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,
    output logic [G_DATAWIDTH-1:0]     m_axi_wdata,
    output logic [G_DATAWIDTH/8-1:0]   m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,
    input  logic [G_ID_WIDTH-1:0]      m_axi_bid,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,
    output logic [G_ID_WIDTH-1:0]      m_axi_arid,
    output logic [G_ADDRWIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [G_ID_WIDTH-1:0]      m_axi_rid,
    input  logic [G_DATAWIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam int unsigned BYTES       = G_DATAWIDTH / 8;
    localparam int unsigned BURST_BYTES = G_BURST_LEN * BYTES;
    localparam logic [7:0]  LAST_BEAT   = 8'(G_BURST_LEN - 1);
    localparam logic [G_ADDRWIDTH-1:0] BEAT_STEP  = G_ADDRWIDTH'(BYTES);
    localparam logic [G_ADDRWIDTH-1:0] BURST_STEP = G_ADDRWIDTH'(BURST_BYTES);
    localparam logic [G_ADDRWIDTH-1:0] LAST_BASE  =
        G_ADDRWIDTH'((longint'(1) << G_ADDRWIDTH) - longint'(BURST_BYTES));

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                  state;
    logic [31:0]             seed_q;
    logic [G_ADDRWIDTH-1:0]  addr;
    logic [G_ADDRWIDTH-1:0]  beat_addr;
    logic [7:0]              beat;

    logic                    last_burst;
    logic                    beat_last;
    logic                    err_hit;
    logic [G_ADDRWIDTH-1:0]  err_addr;
    logic [G_DATAWIDTH-1:0]  expected;

    // Low 32 bits are addr^seed; wider buses repeat that word, narrower ones truncate it.
    function automatic logic [G_DATAWIDTH-1:0] pattern(input logic [G_ADDRWIDTH-1:0] a,
                                                       input logic [31:0] s);
        logic [31:0]            p;
        logic [G_DATAWIDTH-1:0] w;
        p = 32'(a) ^ s;
        w = '0;
        for (int unsigned i = 0; i < G_DATAWIDTH; i++) begin
            w[i] = p[i[4:0]];
        end
        return w;
    endfunction

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = addr;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = 3'($clog2(BYTES));
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = '1;
    assign m_axi_arid    = G_ID_WIDTH'(1);
    assign m_axi_araddr  = addr;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = 3'($clog2(BYTES));
    assign m_axi_arburst = 2'b01;

    always_comb begin
        last_burst = (addr == LAST_BASE);
        beat_last  = (beat == LAST_BEAT);
        expected   = pattern(beat_addr, seed_q);
        err_hit    = 1'b0;
        err_addr   = addr;
        case (state)
            WR_RESP: begin
                if (m_axi_bvalid && (m_axi_bresp != 2'b00 || m_axi_bid != '0)) begin
                    err_hit = 1'b1;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid && (m_axi_rdata != expected || m_axi_rresp != 2'b00 ||
                                     m_axi_rid != G_ID_WIDTH'(1) ||
                                     m_axi_rlast != beat_last)) begin
                    err_hit  = 1'b1;
                    err_addr = beat_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            state          <= IDLE;
            seed_q         <= '0;
            addr           <= '0;
            beat_addr      <= '0;
            beat           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            m_axi_awvalid  <= 1'b0;
            m_axi_wvalid   <= 1'b0;
            m_axi_wdata    <= '0;
            m_axi_wlast    <= 1'b0;
            m_axi_bready   <= 1'b0;
            m_axi_arvalid  <= 1'b0;
            m_axi_rready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        seed_q         <= seed;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        addr           <= '0;
                        m_axi_awvalid  <= 1'b1;
                        state          <= WR_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        m_axi_wvalid  <= 1'b1;
                        m_axi_wdata   <= pattern(addr, seed_q);
                        m_axi_wlast   <= (LAST_BEAT == 8'd0);
                        beat          <= '0;
                        beat_addr     <= addr;
                        state         <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    // wvalid is held high for the whole state, so wready alone marks a beat
                    if (m_axi_wready) begin
                        if (beat_last) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            m_axi_bready <= 1'b1;
                            state        <= WR_RESP;
                        end else begin
                            beat        <= beat + 8'd1;
                            beat_addr   <= beat_addr + BEAT_STEP;
                            m_axi_wdata <= pattern(beat_addr + BEAT_STEP, seed_q);
                            m_axi_wlast <= (beat + 8'd1 == LAST_BEAT);
                        end
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (last_burst) begin
                            addr          <= '0;
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_ADDR;
                        end else begin
                            addr          <= addr + BURST_STEP;
                            m_axi_awvalid <= 1'b1;
                            state         <= WR_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        beat          <= '0;
                        beat_addr     <= addr;
                        state         <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_rvalid) begin
                        if (beat_last) begin
                            m_axi_rready <= 1'b0;
                            if (last_burst) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                // include an error on this final beat, which lands in err_count on the same edge
                                pass  <= (err_count == '0) && !err_hit;
                                state <= DONE;
                            end else begin
                                addr          <= addr + BURST_STEP;
                                m_axi_arvalid <= 1'b1;
                                state         <= RD_ADDR;
                            end
                        end else begin
                            beat      <= beat + 8'd1;
                            beat_addr <= beat_addr + BEAT_STEP;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (err_hit) begin
                if (err_count != '1) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == '0) begin
                    first_err_addr <= err_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: behavioural AXI slave with stalls and fault
// injection, expectation queues filled at start, and a separate monitor.
module tb_axi_mem_tester;

    localparam int DW     = 32;
    localparam int AW     = 10;
    localparam int IW     = 4;
    localparam int BL     = 16;
    localparam int NBURST = (1 << AW) / (BL * 4);

    logic          s_aclk = 1'b0;
    logic          s_areset;
    logic          start;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [DW/8-1:0] m_axi_wstrb;

    always #5 s_aclk = ~s_aclk;

    axi_mem_tester #(
        .G_DATAWIDTH(DW),
        .G_ADDRWIDTH(AW),
        .G_ID_WIDTH (IW),
        .G_BURST_LEN(BL)
    ) dut (
        .s_aclk        (s_aclk),
        .s_areset      (s_areset),
        .start         (start),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    typedef struct {
        int            err;
        logic [AW-1:0] first;
        bit            pass;
    } res_t;

    logic [AW-1:0] q_aw[$];
    logic [AW-1:0] q_ar[$];
    logic [32:0]   q_w[$];
    res_t          q_res[$];
    bit            exp_pass;

    // Expected outcome of a whole run, from the fault configuration alone.
    function automatic res_t model(input int corrupt, input int bburst, input int ridaddr);
        res_t r;
        r.err   = 0;
        r.first = '0;
        for (int b = 0; b < NBURST; b++) begin
            if (b == bburst) begin
                if (r.err == 0) r.first = AW'(b * BL * 4);
                if (r.err < 65535) r.err++;
            end
        end
        for (int a = 0; a < (1 << AW); a += 4) begin
            if (a == corrupt || a == ridaddr) begin
                if (r.err == 0) r.first = AW'(a);
                if (r.err < 65535) r.err++;
            end
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic push_run(input logic [31:0] s, input int corrupt, input int bburst,
                            input int ridaddr);
        res_t r;
        for (int b = 0; b < NBURST; b++) begin
            q_aw.push_back(AW'(b * BL * 4));
            q_ar.push_back(AW'(b * BL * 4));
            for (int k = 0; k < BL; k++) begin
                q_w.push_back({(k == BL - 1), 32'(b * BL * 4 + k * 4) ^ s});
            end
        end
        r = model(corrupt, bburst, ridaddr);
        exp_pass = r.pass;
        q_res.push_back(r);
    endtask

    // ---------------- behavioural AXI slave ----------------
    logic [31:0]   mem [0:(1 << AW) / 4 - 1];
    bit            stall_en, flt_bresp, flt_rid;
    int            aw_cnt, w_cnt, ar_cnt, r_cnt;
    int            wr_beat, wr_burst, rd_beat;
    logic [AW-1:0] wr_base, rd_base, p_awaddr, p_araddr, ra;
    logic [31:0]   p_wdata;
    bit            rd_active, p_aw, p_w, p_b, p_ar, p_r;

    function automatic bit pick(input bit en, input int cnt);
        return !en || cnt >= 5 || ($urandom_range(0, 1) == 1);
    endfunction

    // Runs on the falling edge: handshakes seen at the previous negedge completed at the rising edge between.
    always @(negedge s_aclk) begin
        if (s_areset) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rid = 0;
            m_axi_rresp = 0; m_axi_rlast = 0;
            p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
            wr_beat = 0; wr_burst = 0; rd_beat = 0; rd_active = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
        end else begin
            if (p_b) m_axi_bvalid = 0;
            if (p_aw) begin
                if (p_awaddr == '0) wr_burst = 0;
                wr_base = p_awaddr;
                wr_beat = 0;
            end
            if (p_w) begin
                mem[(int'(wr_base) >> 2) + wr_beat] = p_wdata;
                wr_beat++;
                if (wr_beat == BL) begin
                    m_axi_bvalid = 1;
                    m_axi_bid    = '0;
                    m_axi_bresp  = (flt_bresp && wr_burst == 2) ? 2'b10 : 2'b00;
                    wr_burst++;
                end
            end
            if (p_ar) begin
                rd_base   = p_araddr;
                rd_beat   = 0;
                rd_active = 1;
            end
            if (p_r) begin
                rd_beat++;
                if (rd_beat == BL) rd_active = 0;
            end
            m_axi_awready = pick(stall_en, aw_cnt); aw_cnt = m_axi_awready ? 0 : aw_cnt + 1;
            m_axi_wready  = pick(stall_en, w_cnt);  w_cnt  = m_axi_wready  ? 0 : w_cnt + 1;
            m_axi_arready = pick(stall_en, ar_cnt); ar_cnt = m_axi_arready ? 0 : ar_cnt + 1;
            if (!(m_axi_rvalid && !p_r)) begin
                if (rd_active && pick(stall_en, r_cnt)) begin
                    r_cnt        = 0;
                    ra           = rd_base + AW'(rd_beat * 4);
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mem[int'(ra) >> 2];
                    m_axi_rid    = (flt_rid && ra == AW'(32'h100)) ? IW'(2) : IW'(1);
                    m_axi_rresp  = 2'b00;
                    m_axi_rlast  = (rd_beat == BL - 1);
                end else begin
                    if (rd_active) r_cnt++;
                    m_axi_rvalid = 0;
                    m_axi_rlast  = 0;
                end
            end
            p_aw = m_axi_awvalid && m_axi_awready; p_awaddr = m_axi_awaddr;
            p_w  = m_axi_wvalid && m_axi_wready;   p_wdata  = m_axi_wdata;
            p_b  = m_axi_bvalid && m_axi_bready;
            p_ar = m_axi_arvalid && m_axi_arready; p_araddr = m_axi_araddr;
            p_r  = m_axi_rvalid && m_axi_rready;
        end
    end

    // ---------------- monitor ----------------
    bit          aw_held, ar_held, done_prev;
    logic [63:0] aw_snap, ar_snap;

    always begin
        @(negedge s_aclk);
        #1;
        if (s_areset) begin
            aw_held   = 0;
            ar_held   = 0;
            done_prev = 0;
        end else begin
            if (aw_held)
                check("aw_stable", 64'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
                                        m_axi_awburst, m_axi_awid}), aw_snap);
            if (ar_held)
                check("ar_stable", 64'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
                                        m_axi_arburst, m_axi_arid}), ar_snap);
            if (m_axi_awvalid && m_axi_awready) begin
                if (q_aw.size() == 0) check("aw_unexpected", 64'(q_aw.size()), 64'(1));
                else check("aw_fields", 64'({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid}),
                           64'({q_aw.pop_front(), 8'd15, 3'd2, 2'b01, 4'd0}));
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (q_w.size() == 0) check("w_unexpected", 64'(q_w.size()), 64'(1));
                else check("w_beat", 64'({m_axi_wlast, m_axi_wdata, m_axi_wstrb}),
                           64'({q_w.pop_front(), 4'hF}));
            end
            if (m_axi_arvalid && m_axi_arready) begin
                if (q_ar.size() == 0) check("ar_unexpected", 64'(q_ar.size()), 64'(1));
                else check("ar_fields", 64'({m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid}),
                           64'({q_ar.pop_front(), 8'd15, 3'd2, 2'b01, 4'd1}));
            end
            if (done && !done_prev) begin
                if (q_res.size() == 0) check("done_unexpected", 64'(q_res.size()), 64'(1));
                else begin
                    res_t r;
                    r = q_res.pop_front();
                    check("result", 64'({pass, err_count, first_err_addr, busy}),
                          64'({r.pass, 16'(r.err), r.first, 1'b0}));
                end
            end
            aw_held = m_axi_awvalid && !m_axi_awready;
            aw_snap = 64'({m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid});
            ar_held = m_axi_arvalid && !m_axi_arready;
            ar_snap = 64'({m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid});
            done_prev = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_run(input logic [31:0] s, input int corrupt, input int bburst,
                             input int ridaddr);
        @(negedge s_aclk);
        seed  = s;
        start = 1;
        push_run(s, corrupt, bburst, ridaddr);
        @(negedge s_aclk);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge s_aclk);
            n++;
        end
        check({name, "_done_in_time"}, 64'(done), 64'(1));
    endtask

    task automatic post_done(input string name);
        repeat (3) @(negedge s_aclk);
        #2;
        check({name, "_sticky"}, 64'({done, busy, pass}), 64'({1'b1, 1'b0, exp_pass}));
        check({name, "_drained"}, 64'(q_aw.size() + q_w.size() + q_ar.size() + q_res.size()), 64'(0));
    endtask

    task automatic wait_cycles_for_rready(output bit seen);
        int n = 0;
        while (!m_axi_rready && n < 20000) begin
            @(negedge s_aclk);
            #2;
            n++;
        end
        seen = m_axi_rready;
    endtask

    initial begin
        bit seen;
        int n;
        s_areset  = 1;
        start     = 0;
        seed      = '0;
        stall_en  = 0;
        flt_bresp = 0;
        flt_rid   = 0;
        repeat (3) @(negedge s_aclk);
        #2;
        check("reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'(0));
        check("reset_status", 64'({busy, done, pass}), 64'(0));
        check("reset_errs", 64'({err_count, first_err_addr}), 64'(0));
        @(negedge s_aclk);
        s_areset = 0;

        // clean run, seed 0, no stalls
        start_run(32'h0, -1, -1, -1);
        #2;
        check("busy_after_start", 64'({busy, done}), 64'({1'b1, 1'b0}));
        wait_done("run_a");
        post_done("run_a");

        // stalls everywhere; a start pulse during the read phase must be ignored
        stall_en = 1;
        start_run(32'hA5A5_0000, -1, -1, -1);
        wait_cycles_for_rready(seen);
        check("rd_phase_reached", 64'(seen), 64'(1));
        @(negedge s_aclk);
        start = 1;
        @(negedge s_aclk);
        start = 0;
        wait_done("run_b");
        post_done("run_b");

        // backdoor corruption of one word after the write phase
        start_run($urandom, 32'h44, -1, -1);
        n = 0;
        while (!m_axi_arvalid && n < 20000) begin
            @(negedge s_aclk);
            n++;
        end
        check("wr_phase_end", 64'(m_axi_arvalid), 64'(1));
        #2;
        mem[32'h44 >> 2] = mem[32'h44 >> 2] ^ 32'h0000_0100;
        wait_done("run_c");
        post_done("run_c");

        // restart clears status; SLVERR on 3rd write burst and bad rid at 0x100
        flt_bresp = 1;
        flt_rid   = 1;
        start_run($urandom, -1, 2, 32'h100);
        #2;
        check("restart_clears", 64'({done, err_count, busy}), 64'({1'b0, 16'd0, 1'b1}));
        wait_done("run_d");
        post_done("run_d");
        flt_bresp = 0;
        flt_rid   = 0;

        // reset in the middle of write beat 7
        start_run($urandom, -1, -1, -1);
        n = 0;
        do begin
            @(negedge s_aclk);
            #2;
            n++;
        end while (!(wr_beat == 7 && m_axi_wvalid) && n < 20000);
        check("beat7_reached", 64'(wr_beat == 7 && m_axi_wvalid), 64'(1));
        s_areset = 1;
        q_aw.delete();
        q_w.delete();
        q_ar.delete();
        q_res.delete();
        @(negedge s_aclk);
        #2;
        check("midburst_reset_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}), 64'(0));
        check("midburst_reset_status", 64'({busy, done, err_count}), 64'(0));
        @(negedge s_aclk);
        s_areset = 0;
        stall_en = 0;

        start_run(32'h1234_5678, -1, -1, -1);
        wait_done("run_f");
        post_done("run_f");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_mem_tester.md
Name: axi_mem_tester

Overview:
- AXI4 burst master that sits directly upstream of the axi_2p memory slave and drives its s_axi_* port.
- On start it fills the whole address space with a seeded pattern using INCR write bursts, then reads everything back and checks it with INCR read bursts.
- Reports pass/fail, an error count and the first failing address.
- Serves as the self-checking traffic source for memory bring-up and regression.

Parameters:
G_DATAWIDTH, 32, AXI data width in bits (multiple of 8)
G_ADDRWIDTH, 10, AXI byte-address width; test region is 0 .. 2^G_ADDRWIDTH-1
G_ID_WIDTH, 4, AXI ID width
G_BURST_LEN, 16, beats per burst (1..256, power of two); total region must be a multiple of G_BURST_LEN*G_DATAWIDTH/8

Ports:
s_aclk  in  1  clock
s_areset  in  1  synchronous active-high reset
start  in  1  single-cycle start request; sampled only in IDLE
seed  in  32  pattern seed, latched on accepted start
busy  out  1  high from accepted start until DONE
done  out  1  sticky; set on completion, cleared by next accepted start
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  16  saturating error count
first_err_addr  out  G_ADDRWIDTH  byte address of first error (0 if none)
m_axi_aw*  out  awid[G_ID_WIDTH], awaddr[G_ADDRWIDTH], awlen[8], awsize[3], awburst[2], awvalid; awready in
m_axi_w*  out  wdata[G_DATAWIDTH], wstrb[G_DATAWIDTH/8], wlast, wvalid; wready in
m_axi_b*  in  bid[G_ID_WIDTH], bresp[2], bvalid; bready out
m_axi_ar*  out  arid, araddr, arlen, arsize, arburst, arvalid; arready in
m_axi_r*  in  rid, rdata, rresp, rlast, rvalid; rready out

Behaviour:
- Reset: all valid/ready outputs 0, busy=0, done=0, pass=0, err_count=0, first_err_addr=0, FSM=IDLE, address counter 0. Reset takes effect at the next edge, including mid-burst. The slave must be reset together with this block.
- Constants: awlen=arlen=G_BURST_LEN-1; awsize=arsize=log2(G_DATAWIDTH/8); awburst=arburst=2'b01 (INCR); wstrb all ones; awid=0; arid=1.
- Pattern: word at byte address A = zero-extend(A) XOR seed, truncated or replicated to G_DATAWIDTH (low 32 bits = A^seed).
- Only one burst is outstanding at a time. Address is kept in a burst-aligned counter that advances by G_BURST_LEN*bytes per burst.
- FSM:
  - IDLE: start=1 -> latch seed, clear err_count, first_err_addr, done and pass; addr=0; go to WR_ADDR. In all other states start is ignored.
  - WR_ADDR: awvalid=1 with current addr; hold all AW fields stable until awready. Handshake -> WR_DATA.
  - WR_DATA: wvalid=1 from the first cycle after the AW handshake. Beat counter advances on wvalid&wready. wlast=1 exactly on beat G_BURST_LEN-1. Last handshake -> WR_RESP.
  - WR_RESP: bready=1. On bvalid: error if bresp!=OKAY or bid!=0. If last burst -> addr=0, RD_ADDR; else advance addr, WR_ADDR.
  - RD_ADDR: arvalid=1, held stable until arready -> RD_DATA.
  - RD_DATA: rready=1. Each rvalid beat: compare rdata to the expected pattern. A beat with any of the following counts one error (at most one per beat): data mismatch, rresp!=OKAY, rid!=1, or rlast!=(beat==G_BURST_LEN-1). On the beat counted as last, go to RD_ADDR with the next addr, or to DONE if this was the final burst.
  - DONE: busy=0, done=1, pass=(err_count==0); next cycle IDLE (done/pass remain).
- Error recording:
  - err_count saturates at 16'hFFFF.
  - first_err_addr is captured on the first error only.
  - Write-response errors record that burst's start address; read errors record the beat address.
- busy is high in every state except IDLE and DONE.
- No combinational path from any input to any output valid/ready.

Test Plan:
- Defaults, with axi_2p as slave, seed=0, start pulse -> 16 AW + 16 AR bursts of 16 beats at 0x000,0x040..0x3C0; done=1, pass=1, err_count=0.
- seed=32'hA5A5_0000, random awready/wready/arready/rvalid stalls (up to 5 cycles) -> AW/AR fields stable while stalled, wlast on beat 15 only, pass=1.
- After the write phase, backdoor-corrupt the word at 0x044 -> err_count=1, first_err_addr=0x044, pass=0.
- Slave model returns bresp=SLVERR on the 3rd write burst and rid=2 on one read beat at 0x100 -> err_count=2, first_err_addr=0x080.
- start pulsed while busy in RD_DATA -> ignored, run completes normally. A second start after done clears done and err_count in the next cycle.
- s_areset asserted mid-WR_DATA beat 7 -> next edge: all valids 0, busy=0, done=0. A fresh start then runs to pass=1.
